mult_arb: RTL
=============

# mult_arb

Two-channel round-robin arbiter that shares one unsigned 8x8 multiplier between two requesters. Each requester presents operands with a REQ/ACK handshake; the arbiter grants one channel per cycle, registers the product, and returns it to the granting channel with VALID/RDY back-pressure. It sits between the operand producers and the `mult` datapath, and is started and halted by the same `START`/`HALT` control as the other kadai blocks.

## Interface
- No parameters. Operand width is fixed at 8 bits and product width at 16 bits.
- `CLK  in  1` — single clock, rising edge.
- `RST  in  1` — synchronous, active-high reset.
- `START  in  1` — begin arbitration. Acted on only in S_IDLE.
- `HALT  in  1` — stop issuing grants and drain the result. Acted on only in S_RUN.
- `REQ0, REQ1  in  1` — channel n requests one multiply. `An`/`Bn` must be stable while `REQn` is high.
- `A0, B0, A1, B1  in  8` — unsigned operands.
- `ACK0, ACK1  out  1` — combinational grant. Operands are captured on the edge where ACKn=1.
- `X0, X1  out  16` — product, held until consumed.
- `X0_VALID, X1_VALID  out  1` — result present for channel n.
- `RDY0, RDY1  in  1` — consumer n accepts the result on the edge where Xn_VALID & RDYn.
- `BUSY  out  1` — high when state != S_IDLE.

## Operation
- States: S_IDLE, S_RUN, S_DRAIN. Encoding is 2 bits; any unused code goes to S_IDLE.
- S_IDLE:
  - START → S_RUN.
  - No grants are issued.
  - HALT is ignored. START with HALT in the same cycle → S_RUN.
- S_RUN:
  - HALT → S_DRAIN. No grant is issued in the HALT cycle.
  - Otherwise the arbiter grants when `FREE`, where FREE = ~RVALID | (RVALID & RDY[TAG]).
- Grant rule:
  - Only REQ0 high → ACK0.
  - Only REQ1 high → ACK1.
  - Both high → grant the channel != LAST.
  - At most one ACK is high in any cycle.
- On a grant:
  - RES <= An*Bn, computed by `mult` as full 16-bit unsigned with no truncation.
  - TAG <= n, RVALID <= 1, LAST <= n.
- Result routing:
  - Xn_VALID = RVALID & (TAG==n).
  - Xn = RES when TAG==n, else 0.
- Consumption without a new grant clears RVALID.
- Consumption and a new grant in the same cycle load the new result, so sustained throughput is one product per cycle.
- A requester may hold REQn high across consecutive ACKs. Each ACK is one multiply.
- S_DRAIN:
  - No grants are issued.
  - → S_IDLE on the cycle where ~RVALID, or where RVALID is consumed.
  - START is ignored.
- Reset mid-operation discards any in-flight result with no handshake.

## Timing
- Reset values:
  - State = S_IDLE, RVALID = 0, TAG = 0, LAST = 1, so channel 0 wins the first contention.
  - All ACK and VALID outputs are 0; X0 = X1 = 0; BUSY = 0.
- BUSY rises the cycle after the START edge.
- ACKn is combinational in the same cycle as REQn, once in S_RUN and FREE.
- Latency: Xn_VALID rises on the edge that captures ACKn, so it is visible 1 cycle after the grant cycle.
- If RDYn is low, Xn and Xn_VALID are held and both ACKs stay low.

## Configuration
- `MULT_ARB_CNT_EN` defined:
  - Adds outputs `CNT0, CNT1  out  16`, the grant count per channel.
  - Counts increment on each ACKn and wrap 0xFFFF→0x0000.
  - Cleared by RST and by the START edge in S_IDLE.
- Undefined: the ports and the counter logic are absent. All other behaviour is identical.

## Structure
- Package `mult_arb_pkg` holds:
  - State encodings S_IDLE=2'b00, S_RUN=2'b01, S_DRAIN=2'b10.
  - Width constants OPW=8 and RESW=16.
- Sub-module: the existing combinational `mult` (a, b → x). Its inputs are muxed from the granted channel.

## Test plan
- Reset, then START; REQ0=1, A0=8'd12, B0=8'd13 → ACK0 in cycle 1; X0_VALID=1 with X0=16'd156 next cycle; X1_VALID stays 0.
- Both REQs held, RDY0=RDY1=1, A0=B0=8'hFF, A1=2, B1=3 → ACK0, ACK1, ACK0 … alternate; X0=16'hFE01 and X1=16'd6 alternate at one per cycle.
- RDY1=0 with a result pending for channel 1 → X1 is held, no ACKs; raise RDY1 → it is consumed and a new grant is issued in the same cycle.
- HALT during S_RUN with a result pending and RDY0=0 → no further ACKs; raise RDY0 → S_IDLE, BUSY=0 the next cycle.
- RST asserted while X0_VALID=1 → all outputs 0 next cycle; START with HALT in the same cycle from S_IDLE → S_RUN.
- With `MULT_ARB_CNT_EN`: 5 grants on channel 0 and 3 on channel 1 → CNT0=5, CNT1=3; a new START clears both to 0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared state encodings and datapath widths for the mult_arb two-channel multiplier arbiter.
package mult_arb_pkg;

    localparam int unsigned OPW  = 8;
    localparam int unsigned RESW = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10
    } state_t;

endpackage

// File: rtl/mult.sv
// Combinational unsigned multiplier: full-width product of two operands, no truncation.
module mult
    import mult_arb_pkg::*;
(
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    output logic [RESW-1:0] x
);

    assign x = RESW'(a) * RESW'(b);

endmodule

// File: rtl/mult_arb.sv
// Round-robin arbiter sharing one 8x8 multiplier between two REQ/ACK channels.
// Optional per-channel grant counters are enabled by defining MULT_ARB_CNT_EN.
module mult_arb
    import mult_arb_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            HALT,
    input  logic            REQ0,
    input  logic            REQ1,
    input  logic [OPW-1:0]  A0,
    input  logic [OPW-1:0]  B0,
    input  logic [OPW-1:0]  A1,
    input  logic [OPW-1:0]  B1,
    output logic            ACK0,
    output logic            ACK1,
    output logic [RESW-1:0] X0,
    output logic [RESW-1:0] X1,
    output logic            X0_VALID,
    output logic            X1_VALID,
    input  logic            RDY0,
    input  logic            RDY1,
`ifdef MULT_ARB_CNT_EN
    output logic [15:0]     CNT0,
    output logic [15:0]     CNT1,
`endif
    output logic            BUSY
);

    state_t          state, state_next;
    logic            rvalid;
    logic            tag;
    logic            last;
    logic [RESW-1:0] res;

    logic            rdy_tag, consumed, free, can_grant, grant, gsel;
    logic [OPW-1:0]  mul_a, mul_b;
    logic [RESW-1:0] mul_x;

    assign rdy_tag   = tag ? RDY1 : RDY0;
    assign consumed  = rvalid & rdy_tag;
    assign free      = ~rvalid | consumed;
    assign can_grant = (state == S_RUN) & ~HALT & free;

    // On contention the channel that did not win last time gets the grant.
    assign ACK0  = can_grant & REQ0 & (~REQ1 | last);
    assign ACK1  = can_grant & REQ1 & (~REQ0 | ~last);
    assign grant = ACK0 | ACK1;
    assign gsel  = ACK1;

    assign mul_a = gsel ? A1 : A0;
    assign mul_b = gsel ? B1 : B0;

    mult u_mult (
        .a (mul_a),
        .b (mul_b),
        .x (mul_x)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            rvalid <= 1'b0;
            tag    <= 1'b0;
            last   <= 1'b1;
            res    <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                res    <= mul_x;
                tag    <= gsel;
                last   <= gsel;
                rvalid <= 1'b1;
            end else if (consumed) begin
                rvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:  state_next = START ? S_RUN : S_IDLE;
            S_RUN:   state_next = HALT ? S_DRAIN : S_RUN;
            S_DRAIN: state_next = free ? S_IDLE : S_DRAIN;
            default: state_next = S_IDLE;
        endcase
    end

    assign X0_VALID = rvalid & ~tag;
    assign X1_VALID = rvalid & tag;
    assign X0       = tag ? '0 : res;
    assign X1       = tag ? res : '0;
    assign BUSY     = (state != S_IDLE);

`ifdef MULT_ARB_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST || (state == S_IDLE && START)) begin
            CNT0 <= '0;
            CNT1 <= '0;
        end else begin
            if (ACK0) CNT0 <= CNT0 + 16'd1;
            if (ACK1) CNT1 <= CNT1 + 16'd1;
        end
    end
`endif

endmodule
